// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Multi-cycle sequencer for unsigned 32x32 multiply (MULTU) and
//            divide (DIVU). Drives the shared external ALU one shift-add or
//            shift-subtract step per clock and accumulates into HI/LO.
// Config   : MULDIV_DIVZERO_EN - when defined, DIVU by zero bypasses the
//            iteration loop (done in cycle 1) and raises div_zero_o.
// Ports    : clk            rising-edge clock
//            rst_n          asynchronous active-low reset
//            start_i        request, sampled only in IDLE
//            op_i           0 = MULTU, 1 = DIVU
//            src_a_i        multiplicand / dividend
//            src_b_i        multiplier / divisor
//            busy_o         high while iterating
//            done_o         one-cycle pulse, hi_o/lo_o valid
//            hi_o / lo_o    product[63:32]/[31:0] or remainder/quotient
//            alu_op_o       ALU opcode (4 = ADD, 6 = SUB)
//            alu_a_o/alu_b_o ALU operands
//            alu_result_i   ALU result (combinational, same cycle)
//            alu_carryout_i ALU carry; for SUB, 1 = no borrow
//            div_zero_o     (MULDIV_DIVZERO_EN only) divide-by-zero flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [2:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_carryout_i
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             div_zero_o
`endif
);

    localparam logic [2:0]       c_ALU_ADD  = 3'd4;
    localparam logic [2:0]       c_ALU_SUB  = 3'd6;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] div_s_d;

    // ------------------------------------------------------------------
    // Per-iteration datapath: ALU drive and next HI/LO for one step.
    // ------------------------------------------------------------------
    always_comb begin
        alu_op_o = c_ALU_ADD;
        alu_a_o  = '0;
        alu_b_o  = '0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        // Partial remainder shifted left by one, pulling in the next
        // dividend bit; hi_q[MSB] is the bit that falls off the top.
        div_s_d  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

        if (state_q == S_RUN) begin
            if (!op_q) begin
                // MULTU: conditional add of the multiplier, then shift
                // the 65-bit {carry, hi, lo} right by one.
                alu_op_o = c_ALU_ADD;
                alu_a_o  = hi_q;
                alu_b_o  = opb_q;
                if (lo_q[0]) begin
                    hi_d = {alu_carryout_i, alu_result_i[WIDTH-1:1]};
                    lo_d = {alu_result_i[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[WIDTH-1:1]};
                    lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                end
            end else begin
                // DIVU: restoring division. The effective remainder is
                // 33 bits wide ({hi_q[MSB], s}); if its top bit is set it
                // is certainly >= divisor, so subtract regardless of borrow.
                alu_op_o = c_ALU_SUB;
                alu_a_o  = div_s_d;
                alu_b_o  = opb_q;
                if (hi_q[WIDTH-1] | alu_carryout_i) begin
                    hi_d = alu_result_i;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_s_d;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered busy/done and HI/LO state.
    // ------------------------------------------------------------------
`ifdef MULDIV_DIVZERO_EN
    logic div_zero_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q  <= op_i;
                        opb_q <= src_b_i;
                        cnt_q <= '0;
`ifdef MULDIV_DIVZERO_EN
                        if (op_i && (src_b_i == '0)) begin
                            // Load the natural divide-by-zero result directly.
                            hi_q       <= src_a_i;
                            lo_q       <= '1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            hi_q       <= '0;
                            lo_q       <= src_a_i;
                            busy_q     <= 1'b1;
                            div_zero_q <= 1'b0;
                            state_q    <= S_RUN;
                        end
`else
                        hi_q    <= '0;
                        lo_q    <= src_a_i;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`endif
                    end
                end

                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST_CNT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
`ifdef MULDIV_DIVZERO_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Self-checking bench for alu_muldiv_seq. Models the external ALU,
//            and compares HI/LO, latency, busy/done timing against a plain
//            arithmetic reference (64-bit product, / and %).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_carryout;
`ifdef MULDIV_DIVZERO_EN
    logic        div_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .op_i           (op),
        .src_a_i        (src_a),
        .src_b_i        (src_b),
        .busy_o         (busy),
        .done_o         (done),
        .hi_o           (hi),
        .lo_o           (lo),
        .alu_op_o       (alu_op),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_result_i   (alu_result),
        .alu_carryout_i (alu_carryout)
`ifdef MULDIV_DIVZERO_EN
        ,
        .div_zero_o     (div_zero)
`endif
    );

    // External ALU: ADD reports carry out of bit 31, SUB reports no-borrow.
    always_comb begin
        logic [32:0] sum;
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[31:0];
        alu_carryout = sum[32];
        if (alu_op == 3'd6) begin
            alu_result   = alu_a - alu_b;
            alu_carryout = (alu_a >= alu_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} as defined for each operation.
    function automatic logic [63:0] ref_model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (!o)
            r = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0)
            r = {a, 32'hFFFF_FFFF};
        else
            r = {a % b, a / b};
        return r;
    endfunction

    function automatic int exp_latency(input logic o, input logic [31:0] b);
`ifdef MULDIV_DIVZERO_EN
        return (o && b == 32'd0) ? 1 : 33;
`else
        return (o && b == 32'd0) ? 33 : 33;
`endif
    endfunction

    // Issue one operation and check timing and result. If glitch_cyc > 0,
    // a spurious start with different operands is pulsed in that cycle.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_cyc, input string tag);
        int          cyc;
        int          busy_cnt;
        int          lat;
        logic [63:0] exp;
        exp = ref_model(o, a, b);
        lat = exp_latency(o, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc <= 40) begin
            if (busy) busy_cnt++;
            if (cyc == glitch_cyc) begin
                start = 1'b1; op = ~o; src_a = ~a; src_b = b + 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi_lo"}, {hi, lo}, exp);
`ifdef MULDIV_DIVZERO_EN
        check({tag, " div_zero"}, 64'(div_zero), 64'(o && b == 32'd0));
`endif
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " alu_idle"}, {29'd0, alu_op, alu_a}, {29'd0, 3'd4, 32'd0});
        check({tag, " hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int          cyc;
        int          first_done;
        int          second_done;
        logic        o;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy_done", {62'd0, busy, done}, 64'd0);
        check("rst hi_lo", {hi, lo}, 64'd0);
        check("rst alu", {29'd0, alu_op, alu_a}, {29'd0, 3'd4, 32'd0});
        check("rst alu_b", 64'(alu_b), 64'd0);
`ifdef MULDIV_DIVZERO_EN
        check("rst div_zero", 64'(div_zero), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op(1'b0, 32'd7, 32'd6, 0, "mul_7x6");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
        do_op(1'b1, 32'd100, 32'd7, 0, "div_100_7");
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, "div_max_1");
        do_op(1'b1, 32'h1234, 32'd0, 0, "div_by_zero");
        do_op(1'b0, 32'h0001_2345, 32'h0006_789A, 10, "mul_ignored_start");
        do_op(1'b1, 32'd5, 32'd9, 0, "div_small");

        // Reset mid-operation aborts immediately
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy_done", {62'd0, busy, done}, 64'd0);
        check("abort hi_lo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd7; src_b = 32'd6;
        @(posedge clk);
        #1;
        cyc = 1;
        first_done = 0;
        second_done = 0;
        while (second_done == 0 && cyc <= 80) begin
            if (cyc == 5) begin
                op = 1'b1; src_a = 32'd100; src_b = 32'd7;
            end
            if (done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    check("b2b first_result", {hi, lo}, 64'd42);
                end else begin
                    second_done = cyc;
                end
            end
            if (second_done == 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("b2b first_done", 64'(first_done), 64'd33);
        check("b2b second_done", 64'(second_done), 64'd67);
        check("b2b second_result", {hi, lo}, {32'd2, 32'd14});
        repeat (2) @(posedge clk);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = $urandom_range(2, 15);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(o, a, b, 0, o ? "rand_div" : "rand_mul");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
